// File: rtl/demux_rr_dispatcher.sv
// One-to-four word dispatcher: accepts a word, holds it, and offers it to a
// lane chosen round-robin or by in_dest; round-robin lanes that stall too long are skipped.
//
// state | meaning
// IDLE  | no word held, in_ready=1
// SEND  | word held, offered on lane sel
module demux_rr_dispatcher #(
  parameter int DW  = 8,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          mode,
  input  logic [1:0]    in_dest,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    sel,
  output logic [15:0]   xfer_cnt,
  output logic [7:0]    skip_cnt
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [7:0] TMO_C = 8'(TMO);

  state_t        state, state_nxt;
  logic [1:0]    rr_ptr;
  logic          mode_q;
  logic [7:0]    wait_cnt;
  logic [DW-1:0] hold;
  logic          accept, complete, skip;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Completion is checked before the timeout so a ready lane always wins.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    complete  = 1'b0;
    skip      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready[sel]) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (!mode_q && (wait_cnt == TMO_C)) begin
          skip = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SEND) ? (4'b0001 << sel) : 4'b0000;
  assign out_data  = hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= 2'd0;
      sel      <= 2'd0;
      hold     <= '0;
      mode_q   <= 1'b0;
      wait_cnt <= 8'd0;
      xfer_cnt <= 16'd0;
      skip_cnt <= 8'd0;
    end else if (accept) begin
      hold     <= in_data;
      sel      <= mode ? in_dest : rr_ptr;
      mode_q   <= mode;
      wait_cnt <= 8'd0;
    end else if (complete) begin
      xfer_cnt <= xfer_cnt + 16'd1;
      if (!mode_q) rr_ptr <= sel + 2'd1;
    end else if (skip) begin
      sel      <= sel + 2'd1;
      wait_cnt <= 8'd0;
      skip_cnt <= skip_cnt + 8'd1;
    end else if (state == SEND) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed bench for demux_rr_dispatcher: round-robin order, directed routing,
// backpressure, timeout skip, completion-vs-timeout priority, reset mid-send, counter wrap.
module tb_demux_rr_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        mode;
  logic [1:0]  in_dest;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_data;
  logic [1:0]  sel;
  logic [15:0] xfer_cnt;
  logic [7:0]  skip_cnt;

  int n_cmp = 0;
  int n_err = 0;

  demux_rr_dispatcher #(.DW(8), .TMO(15)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel(sel), .xfer_cnt(xfer_cnt), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; mode = 1'b0;
    in_dest = 2'd0; out_ready = 4'h0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_xfer", 32'(xfer_cnt), 32'd0);
    chk("rst_skip", 32'(skip_cnt), 32'd0);

    // round-robin back to back: lanes 0,1,2,3,0
    out_ready = 4'hF; mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      step();
      chk("rr_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
      chk("rr_data", 32'(out_data), 32'(8'hA0 + 8'(i)));
      chk("rr_in_ready_send", 32'(in_ready), 32'd0);
      step();
      chk("rr_in_ready_idle", 32'(in_ready), 32'd1);
      chk("rr_valid_idle", 32'(out_valid), 32'h0);
    end
    in_valid = 1'b0;
    chk("rr_xfer", 32'(xfer_cnt), 32'd5);

    // directed lane 2; mode/in_dest changes during SEND are ignored
    mode = 1'b1; in_dest = 2'd2; in_data = 8'h5A; out_ready = 4'b0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0; mode = 1'b0; in_dest = 2'd3; out_ready = 4'b0100;
    chk("dir_valid", 32'(out_valid), 32'b0100);
    chk("dir_data", 32'(out_data), 32'h5A);
    chk("dir_sel", 32'(sel), 32'd2);
    step();
    chk("dir_done", 32'(in_ready), 32'd1);
    chk("dir_xfer", 32'(xfer_cnt), 32'd6);

    // rr_ptr was 1 before the directed word and must still be 1
    mode = 1'b0; out_ready = 4'hF; in_data = 8'h11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rr_after_dir", 32'(out_valid), 32'b0010);
    step();
    chk("rr_after_dir_xfer", 32'(xfer_cnt), 32'd7);

    // backpressure on directed lane 1; other lanes' ready is ignored
    mode = 1'b1; in_dest = 2'd1; in_data = 8'h3C; out_ready = 4'b1101; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("bp_valid", 32'(out_valid), 32'b0010);
      chk("bp_data", 32'(out_data), 32'h3C);
      step();
    end
    chk("bp_still_valid", 32'(out_valid), 32'b0010);
    chk("bp_no_skip", 32'(skip_cnt), 32'd0);
    out_ready = 4'b0010;
    step();
    chk("bp_done", 32'(in_ready), 32'd1);
    chk("bp_xfer", 32'(xfer_cnt), 32'd8);

    // move rr_ptr from 2 to 0
    mode = 1'b0; out_ready = 4'hF;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'h20 + 8'(i);
      step();
      in_valid = 1'b0;
      chk("rr_fill_valid", 32'(out_valid), 32'(4'b0100 << i));
      step();
    end
    chk("rr_fill_xfer", 32'(xfer_cnt), 32'd10);

    // timeout skip from lane 0 to lane 1 after 15 stall cycles
    out_ready = 4'b0010; in_data = 8'h77; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("tmo_start_valid", 32'(out_valid), 32'b0001);
    for (int i = 0; i < 15; i++) step();
    chk("tmo_pre_sel", 32'(sel), 32'd0);
    chk("tmo_pre_skip", 32'(skip_cnt), 32'd0);
    step();
    chk("tmo_sel", 32'(sel), 32'd1);
    chk("tmo_valid", 32'(out_valid), 32'b0010);
    chk("tmo_data", 32'(out_data), 32'h77);
    chk("tmo_skip", 32'(skip_cnt), 32'd1);
    step();
    chk("tmo_done", 32'(in_ready), 32'd1);
    chk("tmo_xfer", 32'(xfer_cnt), 32'd11);

    // rr_ptr must now be 2
    out_ready = 4'hF; in_data = 8'h42; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("tmo_rr_next", 32'(out_valid), 32'b0100);
    step();

    // completion coinciding with timeout wins (lane 3)
    out_ready = 4'b0000; in_data = 8'h99; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("coin_valid", 32'(out_valid), 32'b1000);
    for (int i = 0; i < 15; i++) step();
    out_ready = 4'b1000;
    step();
    chk("coin_done", 32'(in_ready), 32'd1);
    chk("coin_skip", 32'(skip_cnt), 32'd1);
    chk("coin_xfer", 32'(xfer_cnt), 32'd13);

    // reset during SEND
    out_ready = 4'b0000; in_data = 8'hEE; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("mid_valid", 32'(out_valid), 32'b0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'h0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_xfer", 32'(xfer_cnt), 32'd0);
    chk("mrst_skip", 32'(skip_cnt), 32'd0);
    chk("mrst_sel", 32'(sel), 32'd0);
    chk("mrst_data", 32'(out_data), 32'h0);

    // xfer_cnt wrap, preloaded near the top
    force dut.xfer_cnt = 16'hFFFE;
    #1;
    release dut.xfer_cnt;
    mode = 1'b1; in_dest = 2'd0; out_ready = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
      step();
      in_valid = 1'b0;
      step();
      chk("wrap_xfer", 32'(xfer_cnt), (i == 0) ? 32'hFFFF : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
